// File: rtl/control_unit.sv
// Instruction sequencer for the 6-instruction processor: PC, IR and the
// fetch/decode/execute FSM. Define CU_HALT_EN to make op 1111 a HALT.
module control_unit #(
    parameter int PC_WIDTH = 16,
    parameter int REGBITS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] i_addr,
    output logic                i_rd,
    input  logic [15:0]         i_data,
    output logic [7:0]          d_addr,
    output logic                d_rd,
    output logic                d_wr,
    output logic [7:0]          rf_w_data,
    output logic [REGBITS-1:0]  rf_w_addr,
    output logic [REGBITS-1:0]  rf_rp_addr,
    output logic [REGBITS-1:0]  rf_rq_addr,
    output logic                rf_w_wr,
    output logic                rf_rp_rd,
    output logic                rf_rq_rd,
    output logic [1:0]          rf_s,
    output logic [1:0]          alu_s,
    input  logic                rf_rp_zero
`ifdef CU_HALT_EN
    ,
    output logic                halted
`endif
);

    typedef enum logic [3:0] {
        INIT, FETCH, DECODE, LOAD, STORE, ADD, LDC, SUB, JMPZ, JMPZ_TAKEN
`ifdef CU_HALT_EN
        , HALT
`endif
    } state_t;

    state_t                state, next;
    logic [PC_WIDTH-1:0]   pc;
    logic [15:0]           ir;

    logic [3:0]            op;
    logic [REGBITS-1:0]    ra, rb, rc;
    logic [7:0]            imm;
    logic [PC_WIDTH-1:0]   offset;

    assign op     = ir[15:12];
    assign ra     = ir[11:8];
    assign rb     = ir[7:4];
    assign rc     = ir[3:0];
    assign imm    = ir[7:0];
    assign offset = {{(PC_WIDTH-8){imm[7]}}, imm};
    assign i_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next;
            case (state)
                INIT:       pc <= '0;
                FETCH: begin
                    ir <= i_data;
                    pc <= pc + PC_WIDTH'(1);
                end
                // PC already points past the jump, so undo that increment
                JMPZ_TAKEN: pc <= pc + offset - PC_WIDTH'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        next       = state;
        i_rd       = 1'b0;
        d_addr     = '0;
        d_rd       = 1'b0;
        d_wr       = 1'b0;
        rf_w_data  = '0;
        rf_w_addr  = '0;
        rf_rp_addr = '0;
        rf_rq_addr = '0;
        rf_w_wr    = 1'b0;
        rf_rp_rd   = 1'b0;
        rf_rq_rd   = 1'b0;
        rf_s       = 2'b00;
        alu_s      = 2'b00;
`ifdef CU_HALT_EN
        halted     = 1'b0;
`endif
        case (state)
            INIT:   next = FETCH;
            FETCH: begin
                i_rd = 1'b1;
                next = DECODE;
            end
            DECODE: begin
                case (op)
                    4'h0:    next = LOAD;
                    4'h1:    next = STORE;
                    4'h2:    next = ADD;
                    4'h3:    next = LDC;
                    4'h4:    next = SUB;
                    4'h5:    next = JMPZ;
`ifdef CU_HALT_EN
                    4'hF:    next = HALT;
`endif
                    default: next = FETCH;
                endcase
            end
            LOAD: begin
                d_addr    = imm;
                d_rd      = 1'b1;
                rf_s      = 2'b01;
                rf_w_addr = ra;
                rf_w_wr   = 1'b1;
                next      = FETCH;
            end
            STORE: begin
                d_addr     = imm;
                d_wr       = 1'b1;
                rf_rp_addr = ra;
                rf_rp_rd   = 1'b1;
                next       = FETCH;
            end
            ADD, SUB: begin
                rf_rp_addr = rb;
                rf_rq_addr = rc;
                rf_rp_rd   = 1'b1;
                rf_rq_rd   = 1'b1;
                alu_s      = (state == ADD) ? 2'b01 : 2'b10;
                rf_w_addr  = ra;
                rf_w_wr    = 1'b1;
                next       = FETCH;
            end
            LDC: begin
                rf_w_data = imm;
                rf_s      = 2'b10;
                rf_w_addr = ra;
                rf_w_wr   = 1'b1;
                next      = FETCH;
            end
            JMPZ: begin
                rf_rp_addr = ra;
                rf_rp_rd   = 1'b1;
                next       = rf_rp_zero ? JMPZ_TAKEN : FETCH;
            end
            JMPZ_TAKEN: next = FETCH;
`ifdef CU_HALT_EN
            HALT: begin
                halted = 1'b1;
                next   = HALT;
            end
`endif
            default: next = INIT;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed programs plus a random
// program run, checked cycle-by-cycle against an instruction-level model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_addr;
    logic        i_rd;
    logic [15:0] i_data;
    logic [7:0]  d_addr;
    logic        d_rd, d_wr;
    logic [7:0]  rf_w_data;
    logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr;
    logic        rf_w_wr, rf_rp_rd, rf_rq_rd;
    logic [1:0]  rf_s, alu_s;
    logic        rf_rp_zero = 1'b0;
    logic        halted;

    logic [15:0] imem [0:65535];
    logic [53:0] obs;
    logic [53:0] exp_q [$];
    logic [15:0] mpc;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign i_data = imem[i_addr];
    assign obs = {i_addr, i_rd, d_addr, d_rd, d_wr, rf_w_data, rf_w_addr,
                  rf_rp_addr, rf_rq_addr, rf_w_wr, rf_rp_rd, rf_rq_rd, rf_s, alu_s};

`ifndef CU_HALT_EN
    assign halted = 1'b0;
`endif

    control_unit dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr),
        .rf_w_data(rf_w_data), .rf_w_addr(rf_w_addr),
        .rf_rp_addr(rf_rp_addr), .rf_rq_addr(rf_rq_addr),
        .rf_w_wr(rf_w_wr), .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd),
        .rf_s(rf_s), .alu_s(alu_s), .rf_rp_zero(rf_rp_zero)
`ifdef CU_HALT_EN
        , .halted(halted)
`endif
    );

    function automatic logic [53:0] mk(
        input logic [15:0] a, input logic ird, input logic [7:0] da,
        input logic drd, input logic dwr, input logic [7:0] wd,
        input logic [3:0] wa, input logic [3:0] pa, input logic [3:0] qa,
        input logic ww, input logic prd, input logic qrd,
        input logic [1:0] s, input logic [1:0] alu);
        return {a, ird, da, drd, dwr, wd, wa, pa, qa, ww, prd, qrd, s, alu};
    endfunction

    // Expected per-cycle outputs of the instruction at mpc; advances mpc.
    task automatic model_instr(input bit z);
        logic [15:0] ins, pc1;
        logic [3:0]  op, ra, rb, rc;
        logic [7:0]  imm;
        ins = imem[mpc];
        op = ins[15:12]; ra = ins[11:8]; rb = ins[7:4]; rc = ins[3:0]; imm = ins[7:0];
        pc1 = mpc + 16'd1;
        exp_q.delete();
        exp_q.push_back(mk(mpc, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(pc1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            4'h0: exp_q.push_back(mk(pc1, 0, imm, 1, 0, 0, ra, 0, 0, 1, 0, 0, 2'b01, 0));
            4'h1: exp_q.push_back(mk(pc1, 0, imm, 0, 1, 0, 0, ra, 0, 0, 1, 0, 0, 0));
            4'h2: exp_q.push_back(mk(pc1, 0, 0, 0, 0, 0, ra, rb, rc, 1, 1, 1, 0, 2'b01));
            4'h3: exp_q.push_back(mk(pc1, 0, 0, 0, 0, imm, ra, 0, 0, 1, 0, 0, 2'b10, 0));
            4'h4: exp_q.push_back(mk(pc1, 0, 0, 0, 0, 0, ra, rb, rc, 1, 1, 1, 0, 2'b10));
            4'h5: begin
                exp_q.push_back(mk(pc1, 0, 0, 0, 0, 0, 0, ra, 0, 0, 1, 0, 0, 0));
                if (z) exp_q.push_back(mk(pc1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            default: ;
        endcase
        mpc = (op == 4'h5 && z) ? mpc + {{8{imm[7]}}, imm} : pc1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mpc = 16'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 54'h0) begin bad++; $display("FAIL reset_low got=%h exp=%h", obs, 54'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (obs !== 54'h0) begin bad++; $display("FAIL reset_init got=%h exp=%h", obs, 54'h0); end
        @(negedge clk);
        total++;
        if (obs !== mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_first_fetch got=%h exp=%h", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_arith();
        imem[0] = 16'h3105; imem[1] = 16'h32FD; imem[2] = 16'h2312; imem[3] = 16'h7000;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            model_instr(0);
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (obs !== exp_q[k]) begin
                    bad++; $display("FAIL arith i%0d c%0d got=%h exp=%h", n, k, obs, exp_q[k]);
                end
                @(negedge clk);
            end
        end
        total++;
        if (i_addr !== 16'd3 || i_rd !== 1'b1) begin
            bad++; $display("FAIL arith_after9 got=%h/%b exp=0003/1", i_addr, i_rd);
        end
    endtask

    task automatic test_memory();
        imem[0] = 16'h0410; imem[1] = 16'h1420;
        do_reset();
        for (int n = 0; n < 2; n++) begin
            model_instr(0);
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (obs !== exp_q[k]) begin
                    bad++; $display("FAIL memory i%0d c%0d got=%h exp=%h", n, k, obs, exp_q[k]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jmpz();
        bit zs [2][11];
        for (int a = 0; a < 11; a++) imem[a] = 16'h7000;
        imem[5] = 16'h5003; imem[10] = 16'h50FE;
        for (int a = 0; a < 11; a++) begin zs[0][a] = 1'b1; zs[1][a] = (a == 10); end
        for (int sc = 0; sc < 2; sc++) begin
            do_reset();
            for (int n = 0; n < (sc == 0 ? 6 : 11); n++) begin
                rf_rp_zero = zs[sc][mpc[3:0]];
                model_instr(rf_rp_zero);
                for (int k = 0; k < exp_q.size(); k++) begin
                    total++;
                    if (obs !== exp_q[k]) begin
                        bad++; $display("FAIL jmpz s%0d i%0d c%0d got=%h exp=%h", sc, n, k, obs, exp_q[k]);
                    end
                    @(negedge clk);
                end
                if (sc == 1 && n == 5) begin
                    total++;
                    if (i_addr !== 16'd6) begin bad++; $display("FAIL jmpz_not_taken got=%h exp=0006", i_addr); end
                end
            end
            total++;
            if (i_addr !== 16'd8 || i_rd !== 1'b1) begin
                bad++; $display("FAIL jmpz_target s%0d got=%h exp=0008", sc, i_addr);
            end
        end
        rf_rp_zero = 1'b0;
    endtask

    task automatic test_wrap();
        imem[0] = 16'h50FF; imem[16'hFFFF] = 16'h7000;
        do_reset();
        for (int n = 0; n < 2; n++) begin
            model_instr(1);
            rf_rp_zero = 1'b1;
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (obs !== exp_q[k]) begin
                    bad++; $display("FAIL wrap i%0d c%0d got=%h exp=%h", n, k, obs, exp_q[k]);
                end
                @(negedge clk);
            end
        end
        total++;
        if (i_addr !== 16'h0000 || i_rd !== 1'b1) begin
            bad++; $display("FAIL wrap_next got=%h exp=0000", i_addr);
        end
        rf_rp_zero = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        imem[0] = 16'h2312;
        do_reset();
        repeat (2) @(negedge clk);
        total++;
        if (rf_w_wr !== 1'b1) begin bad++; $display("FAIL midop_exec got=%b exp=1", rf_w_wr); end
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 54'h0) begin bad++; $display("FAIL midop_drop got=%h exp=%h", obs, 54'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL midop_refetch got=%h exp=%h", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h5, 4'h6, 4'h7, 4'hE};
        for (int a = 0; a < 65536; a++) imem[a] = 16'h0;
        for (int a = 0; a < 256; a++) begin
            imem[a] = {ops[$urandom_range(9)], 12'($urandom)};
            if (imem[a][15:12] == 4'h5) imem[a][7:0] = 8'($signed($urandom_range(16)) - 8);
        end
        do_reset();
        for (int n = 0; n < 300; n++) begin
            rf_rp_zero = 1'($urandom);
            model_instr(rf_rp_zero);
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (obs !== exp_q[k]) begin
                    bad++; $display("FAIL random i%0d c%0d got=%h exp=%h", n, k, obs, exp_q[k]);
                end
                @(negedge clk);
            end
        end
        rf_rp_zero = 1'b0;
    endtask

    task automatic test_halt();
        imem[0] = 16'hF000; imem[1] = 16'h7000;
        do_reset();
        model_instr(0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs !== exp_q[k] || halted !== 1'b0) begin
                bad++; $display("FAIL halt_fd c%0d got=%h/%b exp=%h/0", k, obs, halted, exp_q[k]);
            end
            @(negedge clk);
        end
`ifdef CU_HALT_EN
        for (int c = 0; c < 20; c++) begin
            total++;
            if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0) || halted !== 1'b1) begin
                bad++; $display("FAIL halt_hold c%0d got=%h/%b exp=%h/1", c, obs, halted, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset got=%b exp=0", halted); end
        rst_n = 1'b1;
`else
        total++;
        if (obs !== mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL halt_nop got=%h exp=%h", obs, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
`endif
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) imem[a] = 16'h0;
        mpc = 16'h0;
        test_reset();
        test_arith();
        test_memory();
        test_jmpz();
        test_wrap();
        test_reset_mid_op();
        test_random();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
